multiple_operand_adder_4x4: RTL and testbench
=============================================

Name: multiple_operand_adder_4x4

Overview:
- Four-operand unsigned adder. Adds x, y, z and w in one pass.
- Two carry-save adder (CSA) levels of full adders reduce the four operands to one sum vector and one carry vector.
- A ripple carry-propagate adder (CPA) then produces the final result, which is registered.
- Used as an arithmetic leaf in datapaths that accumulate several small operands in one cycle. It accepts one new operand set per clock.

Parameters:
- WIDTH, 4, operand width in bits. The output width is WIDTH+3 (7 at the default).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set on x/y/z/w is valid this cycle.
- x  input  WIDTH  operand 0, unsigned.
- y  input  WIDTH  operand 1, unsigned.
- z  input  WIDTH  operand 2, unsigned.
- w  input  WIDTH  operand 3, unsigned.
- out_valid  output  1  sum holds a new result.
- sum  output  WIDTH+3  registered x+y+z+w, unsigned, zero-extended.

Behaviour:
- Reset: rst_n low forces sum=0 and out_valid=0 immediately, independent of clk. Both hold at 0 while rst_n is low. Release is synchronised by the clock edge. The first capture happens on the first rising edge with rst_n high.
- Arithmetic:
  - sum = x + y + z + w, exact and unsigned.
  - Maximum is 4*(2^WIDTH-1), which is 60 = 0x3C at the default width. This fits in WIDTH+2 bits.
  - The MSB of sum is always 0. No overflow or wrap is possible.
- Structure:
  - CSA level 1: full adders on x, y, z give s1 (WIDTH bits) and c1 (WIDTH bits, weight shifted left 1).
  - CSA level 2: full adders on s1, c1<<1 and w give s2 and c2 (weight shifted left 1).
  - CPA: ripple adder of s2 + (c2<<1), zero-extended to WIDTH+3.
  - The entire reduction is combinational between the input ports and the output register. There are no input registers.
- Latency: 1 clock. On a rising edge with in_valid=1, sum captures the combinational result and out_valid goes to 1 on the next cycle.
- Throughput: 1 operand set per clock. Back-to-back in_valid=1 yields a new sum every cycle.
- When in_valid=0 at a rising edge:
  - out_valid goes to 0.
  - sum holds its previous value and does not update.
- No backpressure. out_valid is a single-cycle strobe per accepted input and there is no ready signal.
- Reset mid-operation: an assertion of rst_n between the input edge and the output cycle discards the result. sum=0 and out_valid=0 with no stale strobe after release.
- Inputs are don't-care when in_valid=0. X on the operands must not propagate to sum in that case.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> sum=0x00 and out_valid=0 immediately. No out_valid for 1 cycle after release with in_valid=0.
- Single operand sets, each applied with in_valid=1 and checked one cycle later:
  - x=1, y=2, z=3, w=4 -> sum=0x0A, out_valid=1.
  - x=y=z=w=0xF -> sum=0x3C (maximum). Verify sum[6]=0.
  - all zero -> sum=0x00 with out_valid=1.
- Back-to-back sets on consecutive cycles (x,y,z,w):
  - 0xA,0x5,0x5,0xA -> sum=0x1E
  - 8,4,2,1 -> sum=0x0F
  - Results appear on consecutive cycles, each with out_valid=1.
- Hold: apply 1,2,3,4 with in_valid=1, then in_valid=0 with operands changed to 0xF -> sum stays 0x0A and out_valid drops to 0.
- Exhaustive/random: all 2^16 operand combinations (or 10k random) against a reference x+y+z+w, checked at 1-cycle latency. Include an rst_n pulse inserted mid-stream and check that the in-flight result is dropped.

Source files
------------

// File: rtl/multiple_operand_adder_4x4.sv
// Four-operand unsigned adder: two carry-save levels of full adders followed by a
// ripple carry-propagate adder, with the result and a valid strobe registered.
module multiple_operand_adder_4x4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] w,
  output logic             out_valid,
  output logic [WIDTH+2:0] sum
);

  localparam int unsigned L2W  = WIDTH + 1;
  localparam int unsigned CPAW = WIDTH + 2;

  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_c1;
  logic [L2W-1:0]   w_l2_a;
  logic [L2W-1:0]   w_l2_b;
  logic [L2W-1:0]   w_l2_c;
  logic [L2W-1:0]   w_s2;
  logic [L2W-1:0]   w_c2;
  logic [CPAW-1:0]  w_cpa_a;
  logic [CPAW-1:0]  w_cpa_b;
  logic [CPAW-1:0]  w_cpa_s;
  logic             w_carry;
  logic [WIDTH+2:0] w_result;

  logic             r_out_valid;
  logic [WIDTH+2:0] r_sum;

  // CSA level 1: one full adder per bit on x, y, z.
  assign w_s1 = x ^ y ^ z;
  assign w_c1 = (x & y) | (x & z) | (y & z);

  // CSA level 2: c1 carries weight 2, so it enters shifted left by one.
  assign w_l2_a = {1'b0, w_s1};
  assign w_l2_b = {w_c1, 1'b0};
  assign w_l2_c = {1'b0, w};
  assign w_s2   = w_l2_a ^ w_l2_b ^ w_l2_c;
  assign w_c2   = (w_l2_a & w_l2_b) | (w_l2_a & w_l2_c) | (w_l2_b & w_l2_c);

  assign w_cpa_a = {1'b0, w_s2};
  assign w_cpa_b = {w_c2, 1'b0};

  always_comb begin
    w_carry = 1'b0;
    w_cpa_s = '0;
    for (int i = 0; i < CPAW; i++) begin
      w_cpa_s[i] = w_cpa_a[i] ^ w_cpa_b[i] ^ w_carry;
      w_carry    = (w_cpa_a[i] & w_cpa_b[i]) | (w_cpa_a[i] & w_carry) |
                   (w_cpa_b[i] & w_carry);
    end
  end

  // Final carry is kept as the MSB; it is always 0 for in-range operands.
  assign w_result = {w_carry, w_cpa_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
    end else begin
      r_out_valid <= in_valid;
      // Gate on in_valid so undefined operands never reach the register.
      if (in_valid) begin
        r_sum <= w_result;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;

endmodule

// File: tb/tb_multiple_operand_adder_4x4.sv
// Self-checking bench for multiple_operand_adder_4x4: directed vector table, hold and
// reset sequences, and randomized traffic against a plain-arithmetic reference.
module tb_multiple_operand_adder_4x4;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] x, y, z, w;
  logic             out_valid;
  logic [WIDTH+2:0] sum;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    logic [3:0] w;
    logic [6:0] exp_sum;
  } vec_t;

  vec_t vecs[5];

  multiple_operand_adder_4x4 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .x        (x),
    .y        (y),
    .z        (z),
    .w        (w),
    .out_valid(out_valid),
    .sum      (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] exp_s, input logic exp_v);
    tests_run++;
    if (sum !== exp_s || out_valid !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got sum=0x%02h out_valid=%b, expected sum=0x%02h out_valid=%b",
               name, sum, out_valid, exp_s, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    in_valid = v;
    x = a;
    y = b;
    z = c;
    w = d;
  endtask

  initial begin
    logic [6:0] m_sum;
    logic       m_valid;
    logic       v;
    logic [3:0] a, b, c, d;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{x: 4'h1, y: 4'h2, z: 4'h3, w: 4'h4, exp_sum: 7'h0A};
    vecs[1] = '{x: 4'hF, y: 4'hF, z: 4'hF, w: 4'hF, exp_sum: 7'h3C};
    vecs[2] = '{x: 4'h0, y: 4'h0, z: 4'h0, w: 4'h0, exp_sum: 7'h00};
    vecs[3] = '{x: 4'hA, y: 4'h5, z: 4'h5, w: 4'hA, exp_sum: 7'h1E};
    vecs[4] = '{x: 4'h8, y: 4'h4, z: 4'h2, w: 4'h1, exp_sum: 7'h0F};

    // Reset held low across clock edges.
    rst_n = 1'b0;
    drive(1'b1, 4'h7, 4'h7, 4'h7, 4'h7);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", 7'h00, 1'b0);

    // Release at a negedge with in_valid=0: no strobe in the following cycle.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    check("post_reset_idle", 7'h00, 1'b0);

    // Directed vectors back-to-back; each result is checked one cycle later.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].w);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp_sum, 1'b1);
      if (i == 1) begin
        tests_run++;
        if (sum[6] !== 1'b0) begin
          tests_failed++;
          $display("FAIL max_msb: got sum[6]=%b, expected 0", sum[6]);
        end
      end
    end

    // Hold: result stays while in_valid is low even as operands change.
    drive(1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    check("hold_load", 7'h0A, 1'b1);
    drive(1'b0, 4'hF, 4'hF, 4'hF, 4'hF);
    @(negedge clk);
    check("hold_1", 7'h0A, 1'b0);
    @(negedge clk);
    check("hold_2", 7'h0A, 1'b0);

    // Asynchronous reset mid-cycle while a result is present.
    drive(1'b1, 4'h9, 4'h9, 4'h9, 4'h9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 7'h00, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("async_reset_release", 7'h00, 1'b0);

    // Randomized traffic against x+y+z+w, with a reset pulse mid-stream.
    m_sum   = 7'h00;
    m_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      a = 4'($urandom);
      b = 4'($urandom);
      c = 4'($urandom);
      d = 4'($urandom);
      drive(v, a, b, c, d);
      if (i == 5000) begin
        // Input is captured, then reset lands before the output cycle is sampled.
        @(posedge clk);
        #2 rst_n = 1'b0;
        m_sum   = 7'h00;
        m_valid = 1'b0;
        #1 check("rand_reset_drop", m_sum, m_valid);
        @(negedge clk);
        drive(1'b0, a, b, c, d);
        rst_n = 1'b1;
        @(negedge clk);
        check("rand_reset_release", m_sum, m_valid);
      end else begin
        if (v) begin
          m_sum = 7'(a) + 7'(b) + 7'(c) + 7'(d);
        end
        m_valid = v;
        @(negedge clk);
        check("random", m_sum, m_valid);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
